// File: rtl/mem_stall_responder.sv
// Byte-writable word memory that answers CPU IM/DM requests and stalls the
// pipeline for LATENCY cycles per access, returning the merged word.
module mem_stall_responder #(
   parameter int ADDR_WIDTH = 14,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_read,
   input  logic [3:0]  req_web,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rdata,
   output logic        stall
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
   localparam bit         FAST     = (LATENCY == 1);

   logic [1:0]            r_state;
   logic [3:0]            r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [3:0]            r_web;
   logic [31:0]           r_wdata;
   logic                  r_read;
   logic [31:0]           r_rdata;
   logic [31:0]           r_mem [0:DEPTH-1];

   logic                  w_req_valid;
   logic [ADDR_WIDTH-1:0] w_in_idx;
   logic                  w_fire_idle;
   logic                  w_fire_busy;
   logic                  w_fire;
   logic [ADDR_WIDTH-1:0] w_c_idx;
   logic [3:0]            w_c_web;
   logic [31:0]           w_c_wdata;
   logic                  w_c_read;
   logic                  w_upd;
   logic [31:0]           w_old;
   logic [31:0]           w_merged;
   logic                  w_unused_addr;

   assign w_req_valid = req_read | (req_web != 4'hf);
   assign w_in_idx    = req_addr[ADDR_WIDTH+1:2];
   assign w_unused_addr =
      ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

   // With LATENCY=1 the accept edge is also the completion edge,
   // so the live request feeds the array instead of the latches.
   assign w_fire_idle = FAST && (r_state == S_IDLE) && w_req_valid;
   assign w_fire_busy = (r_state == S_BUSY) && (r_cnt == 4'd1);
   assign w_fire      = w_fire_idle | w_fire_busy;

   assign w_c_idx   = w_fire_idle ? w_in_idx  : r_addr;
   assign w_c_web   = w_fire_idle ? req_web   : r_web;
   assign w_c_wdata = w_fire_idle ? req_wdata : r_wdata;
   assign w_c_read  = w_fire_idle ? req_read  : r_read;
   assign w_upd     = w_c_read | (w_c_web != 4'hf);

   assign w_old = r_mem[w_c_idx];

   always_comb begin
      w_merged = w_old;
      for (int b = 0; b < 4; b++) begin
         if (!w_c_web[b]) begin
            w_merged[8*b +: 8] = w_c_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_fire) begin
         for (int b = 0; b < 4; b++) begin
            if (!w_c_web[b]) begin
               r_mem[w_c_idx][8*b +: 8] <= w_c_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_web   <= 4'hf;
         r_wdata <= 32'h0;
         r_read  <= 1'b0;
         r_rdata <= 32'h0;
      end else begin
         if (w_fire && w_upd) begin
            r_rdata <= w_merged;
         end
         unique case (r_state)
            S_IDLE: begin
               if (w_req_valid) begin
                  r_addr  <= w_in_idx;
                  r_web   <= req_web;
                  r_wdata <= req_wdata;
                  r_read  <= req_read;
                  r_cnt   <= CNT_INIT;
                  r_state <= FAST ? S_DONE : S_BUSY;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt - 4'd1;
               if (w_fire_busy) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      stall = 1'b0;
      unique case (r_state)
         S_IDLE:  stall = w_req_valid;
         S_BUSY:  stall = 1'b1;
         S_DONE:  stall = 1'b0;
         default: stall = 1'b0;
      endcase
   end

   assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_stall_responder.sv
// Bench for mem_stall_responder: LATENCY=2 instance driven from a vector
// table plus hand sequences; a LATENCY=1 instance for the fast path.
module tb_mem_stall_responder;

   logic        clk;
   logic        rst;

   logic        a_read;
   logic [3:0]  a_web;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic [31:0] a_rdata;
   logic        a_stall;

   logic        b_read;
   logic [3:0]  b_web;
   logic [31:0] b_addr;
   logic [31:0] b_wdata;
   logic [31:0] b_rdata;
   logic        b_stall;

   int checks;
   int failures;

   logic [31:0] sb[$];

   typedef struct {
      string       nm;
      logic        rd;
      logic [3:0]  web;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   mem_stall_responder #(.ADDR_WIDTH(14), .LATENCY(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_read  (a_read),
      .req_web   (a_web),
      .req_addr  (a_addr),
      .req_wdata (a_wdata),
      .rdata     (a_rdata),
      .stall     (a_stall)
   );

   mem_stall_responder #(.ADDR_WIDTH(14), .LATENCY(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .req_read  (b_read),
      .req_web   (b_web),
      .req_addr  (b_addr),
      .req_wdata (b_wdata),
      .rdata     (b_rdata),
      .stall     (b_stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic chk_sb(input string nm, input logic [31:0] act);
      logic [31:0] exp;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s scoreboard empty act=%h", nm, act);
      end else begin
         exp = sb.pop_front();
         chk(nm, act, exp);
      end
   endtask

   task automatic a_idle();
      a_read  = 1'b0;
      a_web   = 4'hf;
      a_addr  = 32'h0;
      a_wdata = 32'h0;
   endtask

   task automatic b_idle();
      b_read  = 1'b0;
      b_web   = 4'hf;
      b_addr  = 32'h0;
      b_wdata = 32'h0;
   endtask

   // Called at posedge+1 with dut in IDLE; returns at posedge+1 in IDLE.
   task automatic do_access(input vec_t v);
      a_read  = v.rd;
      a_web   = v.web;
      a_addr  = v.addr;
      a_wdata = v.wd;
      sb.push_back(v.exp);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk({v.nm, "_stall"}, 32'(a_stall), 32'd1);
         @(posedge clk);
         #1;
         if (k == 0) begin
            a_read  = 1'b0;
            a_web   = 4'h0;
            a_addr  = 32'h3C;
            a_wdata = $urandom;
         end else begin
            a_idle();
         end
      end
      @(negedge clk);
      chk({v.nm, "_done_stall"}, 32'(a_stall), 32'd0);
      chk_sb({v.nm, "_rdata"}, a_rdata);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      vecs[0] = '{"rd5",    1'b1, 4'hf, 32'h14,       32'h0,        32'hDEADBEEF};
      vecs[1] = '{"wrb1",   1'b0, 4'hd, 32'h0D,       32'h0000AA00, 32'h1122AA44};
      vecs[2] = '{"rd3",    1'b1, 4'hf, 32'h0C,       32'h0,        32'h1122AA44};
      vecs[3] = '{"wrap",   1'b1, 4'hf, 32'h0001_0014, 32'h0,       32'hDEADBEEF};
      vecs[4] = '{"rdwr",   1'b1, 4'he, 32'h14,       32'h00000011, 32'hDEADBE11};
      vecs[5] = '{"wrfull", 1'b0, 4'h0, 32'h20,       32'h12345678, 32'h12345678};
      vecs[6] = '{"rd8",    1'b1, 4'hf, 32'h20,       32'h0,        32'h12345678};
      vecs[7] = '{"wrb3",   1'b0, 4'h7, 32'h14,       32'hAB000000, 32'hABADBE11};

      rst = 1'b0;
      a_idle();
      b_idle();
      repeat (3) begin
         @(negedge clk);
         chk("rst_stall", 32'(a_stall), 32'd0);
         chk("rst_rdata", a_rdata, 32'h0);
         chk("rst_stall1", 32'(b_stall), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_stall", 32'(a_stall), 32'd0);
         chk("idle_rdata", a_rdata, 32'h0);
      end
      @(posedge clk);
      #1;

      dut.r_mem[5] = 32'hDEADBEEF;
      dut.r_mem[3] = 32'h11223344;

      foreach (vecs[i]) begin
         do_access(vecs[i]);
         if (i == 1) begin
            chk("mem3", dut.r_mem[3], 32'h1122AA44);
         end
      end
      chk("mem15_untouched_by_busy_inputs", 32'(sb.size()), 32'd0);

      repeat (2) begin
         @(negedge clk);
         chk("hold_stall", 32'(a_stall), 32'd0);
         chk("hold_rdata", a_rdata, 32'hABADBE11);
      end
      @(posedge clk);
      #1;

      // Request held across DONE must become two accesses
      a_read = 1'b1;
      a_addr = 32'h14;
      for (int k = 0; k < 6; k++) begin
         if (k % 3 == 0) sb.push_back(32'hABADBE11);
         @(negedge clk);
         chk("b2b_stall", 32'(a_stall), (k % 3 != 2) ? 32'd1 : 32'd0);
         if (k % 3 == 2) chk_sb("b2b_rdata", a_rdata);
         @(posedge clk);
         #1;
      end
      a_idle();
      @(negedge clk);
      chk("b2b_after_stall", 32'(a_stall), 32'd0);
      @(posedge clk);
      #1;

      // Reset during BUSY abandons the write
      dut.r_mem[7] = 32'h0BADF00D;
      a_web   = 4'h0;
      a_addr  = 32'h1C;
      a_wdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk("mr_stall", 32'(a_stall), 32'd1);
      @(posedge clk);
      #1;
      a_idle();
      #1;
      rst = 1'b0;
      #1;
      chk("mr_stall_drop", 32'(a_stall), 32'd0);
      chk("mr_rdata", a_rdata, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mr_post_stall", 32'(a_stall), 32'd0);
      chk("mr_mem7", dut.r_mem[7], 32'h0BADF00D);
      @(posedge clk);
      #1;
      do_access('{"rd7", 1'b1, 4'hf, 32'h1C, 32'h0, 32'h0BADF00D});

      // LATENCY=1 instance
      dut1.r_mem[5] = 32'hDEADBEEF;
      b_read = 1'b1;
      b_addr = 32'h14;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) sb.push_back(32'hDEADBEEF);
         @(negedge clk);
         chk("l1_stall", 32'(b_stall), (k % 2 == 0) ? 32'd1 : 32'd0);
         if (k % 2 == 1) chk_sb("l1_rdata", b_rdata);
         @(posedge clk);
         #1;
      end
      b_read  = 1'b0;
      b_web   = 4'he;
      b_wdata = 32'h00000077;
      sb.push_back(32'hDEADBE77);
      @(negedge clk);
      chk("l1w_stall", 32'(b_stall), 32'd1);
      @(posedge clk);
      #1;
      b_idle();
      @(negedge clk);
      chk("l1w_done_stall", 32'(b_stall), 32'd0);
      chk_sb("l1w_rdata", b_rdata);
      chk("l1w_mem5", dut1.r_mem[5], 32'hDEADBE77);
      @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_stall_responder.md
Name: mem_stall_responder

Overview:
- Memory-side responder for the CPU's instruction and data memory ports. It answers the read strobe, active-low byte write enables, address and write data that the CPU drives.
- It stores words in an internal byte-writable array and returns read data.
- It drives the STALL signal, which freezes the CPU pipeline for a fixed access latency.
- One instance serves IM (write enables tied to 4'hf). One instance serves DM.

Parameters:
- ADDR_WIDTH, 14, word-address bits; array depth is 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, stall cycles per access; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_read  input  1  read request (CPU Instr_read / MEM_MemRead).
- req_web  input  4  active-low byte write enables; bit i=0 writes byte i; 4'hf = no write.
- req_addr  input  32  byte address; word index = req_addr[ADDR_WIDTH+1:2]; upper bits ignored, so addresses wrap modulo depth.
- req_wdata  input  32  write data, already lane-aligned by the CPU.
- rdata  output  32  registered read data (CPU Instr_out / data_out).
- stall  output  1  high while an access is in progress (CPU IM_STALL / DM_STALL).

Behaviour:
- Request valid: req_valid = req_read | (req_web != 4'hf).
- Reset (rst=0, async):
  - state=IDLE, counter=0, rdata=32'h0, stall=0.
  - Latched request registers are cleared.
  - Array contents are not reset.
  - A reset mid-access abandons the access with no write performed.
- FSM has 3 states: IDLE, BUSY, DONE.
- IDLE:
  - stall = req_valid (combinational, same cycle).
  - If req_valid, latch addr, web, wdata and read into internal registers, load counter=LATENCY-1, go to BUSY.
  - If LATENCY=1, go straight to the completion edge described below instead of waiting in BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - stall=1. Counter decrements each cycle.
  - On the edge where counter==0 (the completion edge):
    - Perform the write using the latched web/wdata/addr.
    - Load rdata with the array word at the latched addr, with written bytes already merged.
    - Go to DONE.
- Stall length: total stall-high cycles per access = LATENCY exactly. The first stall cycle is the cycle the request appears in IDLE.
- DONE:
  - stall=0; rdata holds the result. The CPU advances its pipeline registers on this edge.
  - Next state is IDLE unconditionally. A request presented during DONE is not accepted; it is evaluated in the following IDLE cycle.
  - This guarantees back-to-back identical requests are treated as two accesses.
- Input changes in BUSY/DONE are ignored; only latched values are used.
- Simultaneous read and write: the write is performed; rdata = merged post-write word.
- Write-only access: rdata is still updated with the merged word.
- Idle/invalid cycles: rdata holds its last value.
- Throughput: one access per LATENCY+1 cycles.
- No X propagation: an uninitialised array read returns whatever the array holds. The bench preloads the array via a hierarchical reference.

Test Plan:
1. Reset and idle: hold rst=0 for 3 cycles, release, drive req_read=0 and req_web=4'hf -> stall=0 and rdata=32'h0 every cycle.
2. Read latency (LATENCY=2): preload word 5 = 32'hDEADBEEF, then present req_read=1, req_addr=32'h14 -> stall high for exactly 2 cycles, then a DONE cycle with stall=0 and rdata=32'hDEADBEEF.
3. Byte write:
   - Preload word 3 = 32'h11223344.
   - Present req_web=4'hd, req_wdata=32'h0000AA00, addr=32'h0D -> after DONE, word 3 = 32'h1122AA44 and rdata=32'h1122AA44.
   - Follow with a read of addr 32'h0C -> rdata=32'h1122AA44.
4. Back-to-back identical reads: hold req_read=1, addr=32'h14 across DONE -> two separate 2-cycle stall windows separated by exactly one stall=0 cycle. Total 6 cycles for two accesses.
5. Wrap and mid-access reset:
   - Read addr 32'h0001_0014 (ADDR_WIDTH=14) -> returns word 5.
   - Start a write of 32'hFFFFFFFF to word 7 with req_web=4'h0, then assert rst during BUSY -> stall drops immediately and word 7 is unchanged.
6. LATENCY=1 build: a read to word 5 -> stall high for 1 cycle, DONE next cycle with correct rdata. Consecutive accesses complete every 2 cycles.
